// File: rtl/if_fetch_unit_pkg.sv
// Shared LC-3b fetch types: machine word, register index, IF/ID packet and fetch FSM states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef struct packed {
    logic     valid;
    lc3b_word pc;
    lc3b_word inst;
    lc3b_reg  sr1;
    lc3b_reg  sr2;
    lc3b_reg  dr_sr;
    logic     sr2_mux_sel;
  } lc3b_ipacket;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_PC_STEP = 16'd2;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read handshake between the fetch unit (master) and memory (slave).
interface if_fetch_unit_if;
  import lc3b_types::*;

  logic     imem_read;
  lc3b_word imem_address;
  lc3b_word imem_rdata;
  logic     imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );

endinterface

// File: rtl/if_fetch_unit_packet_builder.sv
// Combinational decode of a fetched word and its address into an IF/ID packet.
module if_packet_builder
  import lc3b_types::*;
(
  input  lc3b_word    i_word,
  input  lc3b_word    i_addr,
  output lc3b_ipacket o_packet
);

  always_comb begin
    o_packet             = '0;
    o_packet.valid       = 1'b1;
    o_packet.pc          = i_addr;
    o_packet.inst        = i_word;
    o_packet.dr_sr       = i_word[11:9];
    o_packet.sr1         = i_word[8:6];
    o_packet.sr2         = i_word[2:0];
    o_packet.sr2_mux_sel = i_word[5];
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem read handshake and feeds the IF/ID latch through a one-entry hold buffer.
module if_fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  lc3b_word               redirect_pc,
  if_fetch_unit_if.master        imem,
  output lc3b_ipacket            ipacket_out
);

  lc3b_fetch_state r_state;
  lc3b_word        r_pc;
  lc3b_word        r_req_addr;
  lc3b_ipacket     r_hold;
  lc3b_ipacket     r_out;

  lc3b_ipacket     w_packet;
  lc3b_word        w_pc_next;
  lc3b_word        w_redir_pc;
  lc3b_word        w_reset_pc;

  if_packet_builder u_builder (
    .i_word   (imem.imem_rdata),
    .i_addr   (r_req_addr),
    .o_packet (w_packet)
  );

  assign w_pc_next         = r_pc + LC3B_PC_STEP;
  assign w_redir_pc        = redirect_pc & 16'hFFFE;
  assign w_reset_pc        = RESET_PC & 16'hFFFE;
  assign imem.imem_read    = (r_state != HOLD);
  assign imem.imem_address = r_req_addr;
  assign ipacket_out       = r_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= w_reset_pc;
      r_req_addr <= w_reset_pc;
      r_hold     <= '0;
      r_out      <= '0;
    end else if (redirect) begin
      r_pc         <= w_redir_pc;
      r_out.valid  <= 1'b0;
      r_hold.valid <= 1'b0;
      // An outstanding read cannot be cancelled: wait it out in DROP unless it completes this cycle.
      if (r_state == HOLD || imem.imem_resp) begin
        r_state    <= FETCH;
        r_req_addr <= w_redir_pc;
      end else begin
        r_state    <= DROP;
      end
    end else begin
      unique case (r_state)
        FETCH: begin
          if (imem.imem_resp) begin
            r_pc       <= w_pc_next;
            r_req_addr <= w_pc_next;
            if (stall) begin
              r_hold  <= w_packet;
              r_state <= HOLD;
            end else begin
              r_out   <= w_packet;
            end
          end else if (!stall) begin
            r_out.valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            r_out        <= r_hold;
            r_hold.valid <= 1'b0;
            r_req_addr   <= r_pc;
            r_state      <= FETCH;
          end
        end
        DROP: begin
          r_out.valid <= 1'b0;
          if (imem.imem_resp) begin
            r_req_addr <= r_pc;
            r_state    <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit plus a second instance with RESET_PC=16'hFFFE.
module tb_if_fetch_unit;
  import lc3b_types::*;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  lc3b_ipacket pkt;
  lc3b_ipacket pkt2;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit_if bus ();
  if_fetch_unit_if bus2 ();

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .ipacket_out (pkt)
  );

  if_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .imem        (bus2),
    .ipacket_out (pkt2)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic st, input logic rd, input logic [15:0] rpc,
                              input logic rs, input logic [15:0] dat, input logic er, input logic [15:0] ea,
                              input logic ev, input logic [15:0] ep, input logic [15:0] ei);
    vec_t t;
    t.rst = rst; t.stall = st; t.redir = rd; t.rpc = rpc; t.resp = rs; t.rdata = dat;
    t.e_read = er; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep; t.e_inst = ei;
    return t;
  endfunction

  vec_t v[25];

  initial begin
    // Expected fields describe outputs at the start of the row's cycle; inputs apply to that cycle.
    //          rst st rd rpc       rs dat       rd addr      v  pc        inst
    v[0]  = mk(0, 0, 0, 16'h0000, 1, 16'h1283, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    v[1]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h1283);
    v[2]  = mk(0, 0, 0, 16'h0000, 1, 16'h12A5, 1, 16'h0002, 0, 16'h0000, 16'h1283);
    v[3]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 16'h12A5);
    v[4]  = mk(0, 0, 0, 16'h0000, 1, 16'h5005, 1, 16'h0004, 0, 16'h0002, 16'h12A5);
    v[5]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004, 16'h5005);
    v[6]  = mk(0, 1, 0, 16'h0000, 1, 16'h6006, 1, 16'h0006, 1, 16'h0004, 16'h5005);
    v[7]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h5005);
    v[8]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h5005);
    v[9]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 1, 16'h0004, 16'h5005);
    v[10] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 1, 16'h0006, 16'h6006);
    v[11] = mk(0, 0, 0, 16'h0000, 1, 16'h7007, 1, 16'h0008, 0, 16'h0006, 16'h6006);
    v[12] = mk(0, 0, 1, 16'h3001, 0, 16'h0000, 1, 16'h000A, 1, 16'h0008, 16'h7007);
    v[13] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000A, 0, 16'h0008, 16'h7007);
    v[14] = mk(0, 0, 0, 16'h0000, 1, 16'hBAD0, 1, 16'h000A, 0, 16'h0008, 16'h7007);
    v[15] = mk(0, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h3000, 0, 16'h0008, 16'h7007);
    v[16] = mk(0, 0, 1, 16'h4000, 1, 16'hBAD1, 1, 16'h3002, 1, 16'h3000, 16'h1111);
    v[17] = mk(0, 1, 0, 16'h0000, 1, 16'h2222, 1, 16'h4000, 0, 16'h3000, 16'h1111);
    v[18] = mk(0, 1, 1, 16'h5000, 0, 16'h0000, 0, 16'h4002, 0, 16'h3000, 16'h1111);
    v[19] = mk(0, 0, 0, 16'h0000, 1, 16'h3333, 1, 16'h5000, 0, 16'h3000, 16'h1111);
    v[20] = mk(0, 1, 0, 16'h0000, 1, 16'h4444, 1, 16'h5002, 1, 16'h5000, 16'h3333);
    v[21] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h5004, 1, 16'h5000, 16'h3333);
    v[22] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    v[23] = mk(0, 0, 0, 16'h0000, 1, 16'h8888, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    v[24] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h8888);

    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    bus.imem_resp = 1'b0;  bus.imem_rdata = 16'h0000;
    bus2.imem_resp = 1'b0; bus2.imem_rdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("r%0d.imem_read", i),    {15'd0, bus.imem_read}, {15'd0, v[i].e_read});
      chk($sformatf("r%0d.imem_address", i), bus.imem_address,       v[i].e_addr);
      chk($sformatf("r%0d.valid", i),        {15'd0, pkt.valid},     {15'd0, v[i].e_valid});
      chk($sformatf("r%0d.pc", i),           pkt.pc,                 v[i].e_pc);
      chk($sformatf("r%0d.inst", i),         pkt.inst,               v[i].e_inst);
      if (i == 1) begin
        chk("add.dr_sr",  {13'd0, pkt.dr_sr}, 16'd1);
        chk("add.sr1",    {13'd0, pkt.sr1},   16'd2);
        chk("add.sr2",    {13'd0, pkt.sr2},   16'd3);
        chk("add.sr2sel", {15'd0, pkt.sr2_mux_sel}, 16'd0);
      end
      if (i == 3) begin
        chk("imm.dr_sr",  {13'd0, pkt.dr_sr}, 16'd1);
        chk("imm.sr1",    {13'd0, pkt.sr1},   16'd2);
        chk("imm.sr2",    {13'd0, pkt.sr2},   16'd5);
        chk("imm.sr2sel", {15'd0, pkt.sr2_mux_sel}, 16'd1);
      end
      reset         = v[i].rst;
      stall         = v[i].stall;
      redirect      = v[i].redir;
      redirect_pc   = v[i].rpc;
      bus.imem_resp = v[i].resp;
      bus.imem_rdata = v[i].rdata;
    end

    // RESET_PC=16'hFFFE instance: read at FFFE, then PC wraps to 0000.
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; bus.imem_resp = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("w.read0",  {15'd0, bus2.imem_read}, 16'd1);
    chk("w.addr0",  bus2.imem_address, 16'hFFFE);
    chk("w.valid0", {15'd0, pkt2.valid}, 16'd0);
    bus2.imem_resp = 1'b1; bus2.imem_rdata = 16'h0ABC;
    @(negedge clk);
    bus2.imem_resp = 1'b0;
    chk("w.addr1",  bus2.imem_address, 16'h0000);
    chk("w.valid1", {15'd0, pkt2.valid}, 16'd1);
    chk("w.pc1",    pkt2.pc, 16'hFFFE);
    chk("w.inst1",  pkt2.inst, 16'h0ABC);
    bus2.imem_resp = 1'b1; bus2.imem_rdata = 16'h0DEF;
    @(negedge clk);
    bus2.imem_resp = 1'b0;
    chk("w.addr2",  bus2.imem_address, 16'h0002);
    chk("w.pc2",    pkt2.pc, 16'h0000);
    chk("w.inst2",  pkt2.inst, 16'h0DEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
